// File: rtl/singlepulse_pkg.sv
// Shared types and sizing helpers for the single-pulse generator.
`timescale 1ns/1ps
package singlepulse_pkg;

  // Which transition of the load level counts as a trigger.
  typedef enum logic [1:0] {
    RISING  = 2'd0,
    FALLING = 2'd1,
    BOTH    = 2'd2
  } edge_sel_t;

  // Pulse controller states.
  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } sp_state_t;

  localparam int MAX_PULSE_WIDTH = 65535;

  // Bits needed to hold the value pw without wrapping: ceil(log2(pw+1)).
  function automatic int cnt_width(input int pw);
    int w;
    w = 1;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < (64'(pw) + 64'd1)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/singlepulse_edge_det.sv
// Optional load synchronizer, previous-sample register and edge decode.
// Produces a one-cycle trigger, combinational from the sampled level so the
// top-level output flop can rise on the very edge that sees the new level.
`timescale 1ns/1ps
module singlepulse_edge_det
  import singlepulse_pkg::*;
#(
  parameter int        SYNC_STAGES = 0,
  parameter edge_sel_t EDGE_SEL    = RISING
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic trig_o
);

  logic sample;
  logic load_prev_q;
  logic rise;
  logic fall;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      // load is already synchronous to clk: use it directly.
      assign sample = load_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift load through the synchronizer chain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], load_i};
        end
      end

      assign sample = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Remember the last sampled level; cleared so a high load after reset
  // looks like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_prev_q <= 1'b0;
    end else begin
      load_prev_q <= sample;
    end
  end

  assign rise = sample & ~load_prev_q;
  assign fall = ~sample & load_prev_q;

  // Select which transition is reported as a trigger.
  always_comb begin
    trig_o = 1'b0;
    case (EDGE_SEL)
      RISING:  trig_o = rise;
      FALLING: trig_o = fall;
      BOTH:    trig_o = rise | fall;
      default: trig_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/singlepulse.sv
// Single-pulse generator: each detected load edge yields one PULSE_WIDTH-cycle
// high pulse on q. Triggers during an active pulse are dropped.
`timescale 1ns/1ps
module singlepulse
  import singlepulse_pkg::*;
#(
  parameter int        PULSE_WIDTH = 1,
  parameter int        SYNC_STAGES = 0,
  parameter edge_sel_t EDGE_SEL    = RISING
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic q
);

  localparam int              CW   = cnt_width(PULSE_WIDTH);
  localparam logic [CW-1:0]   PW_C = CW'(PULSE_WIDTH);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  sp_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic          q_q;
  logic          trig;

  singlepulse_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_SEL    (EDGE_SEL)
  ) u_edge_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .trig_o (trig)
  );

  // Pulse FSM: the counter holds the number of high cycles already issued,
  // so the pulse ends when it reaches PULSE_WIDTH and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_q <= PULSE;
            cnt_q   <= ONE;
            q_q     <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q >= PW_C) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          q_q     <= 1'b0;
        end
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_singlepulse.sv
// Directed bench for singlepulse: several parameterisations share one clock
// and stimulus timeline; q is sampled 1 ns after clock edges.
`timescale 1ns/1ps
module tb_singlepulse;
  import singlepulse_pkg::*;

  logic clk;
  logic rst_a;
  logic rst_r;
  logic load_a;
  logic load_w;
  logic q_a, q_r, q_b, q_s, q_f, q_w;

  int n_total;
  int n_pass;

  // Defaults: V1/V2
  singlepulse u_a (.clk(clk), .rst_n(rst_a), .load(load_a), .q(q_a));
  // Defaults with mid-pulse reset: V4
  singlepulse u_r (.clk(clk), .rst_n(rst_r), .load(load_a), .q(q_r));
  // Both edges: V5
  singlepulse #(.EDGE_SEL(BOTH)) u_b (.clk(clk), .rst_n(rst_a), .load(load_a), .q(q_b));
  // Two synchronizer stages: V6
  singlepulse #(.SYNC_STAGES(2)) u_s (.clk(clk), .rst_n(rst_a), .load(load_a), .q(q_s));
  // Falling edge, sharing the V4 reset so a high load at release gives nothing
  singlepulse #(.EDGE_SEL(FALLING)) u_f (.clk(clk), .rst_n(rst_r), .load(load_a), .q(q_f));
  // Four-cycle pulse: V3
  singlepulse #(.PULSE_WIDTH(4)) u_w (.clk(clk), .rst_n(rst_a), .load(load_w), .q(q_w));

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic at(input int t);
    while ($time < t) #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_a   = 1'b0;
    rst_r   = 1'b0;
    load_a  = 1'b0;
    load_w  = 1'b0;

    at(5);    chk("reset_q_a", q_a, 1'b0);  chk("reset_q_w", q_w, 1'b0);
    at(20);   rst_a = 1'b1; rst_r = 1'b1;
    at(31);   chk("idle_q_a", q_a, 1'b0);
    at(120);  load_a = 1'b1;
    at(121);  chk("no_edge_yet", q_a, 1'b0);
    at(131);  chk("v1_rise", q_a, 1'b1); chk("v5_rise1", q_b, 1'b1);
              chk("v4_pre", q_r, 1'b1);  chk("v6_not_yet", q_s, 1'b0);
              chk("fall_ignores_rise", q_f, 1'b0);
    at(140);  rst_r = 1'b0;
    at(141);  chk("v4_async_clear", q_r, 1'b0); chk("v1_still_high", q_a, 1'b1);
    at(151);  chk("v1_end", q_a, 1'b0); chk("v5_end1", q_b, 1'b0);
              chk("v6_not_yet2", q_s, 1'b0);
    at(165);  rst_r = 1'b1;
    at(171);  chk("v4_release_pulse", q_r, 1'b1); chk("v6_rise", q_s, 1'b1);
              chk("fall_release_none", q_f, 1'b0); chk("v1_held_low", q_a, 1'b0);
    at(191);  chk("v4_end", q_r, 1'b0); chk("v6_end", q_s, 1'b0);
    at(311);  chk("v1_held_no_repeat", q_a, 1'b0);
    at(320);  load_a = 1'b0;
    at(331);  chk("v2_fall_none", q_a, 1'b0); chk("v5_rise2", q_b, 1'b1);
              chk("fall_pulse", q_f, 1'b1);  chk("v4_fall_none", q_r, 1'b0);
    at(351);  chk("v5_end2", q_b, 1'b0); chk("fall_end", q_f, 1'b0);
              chk("v6_fall_none", q_s, 1'b0);
    at(520);  load_a = 1'b1;
    at(531);  chk("v2_rise", q_a, 1'b1); chk("v5_rise3", q_b, 1'b1);
              chk("v4_later_rise", q_r, 1'b1); chk("fall_on_rise_none", q_f, 1'b0);
              chk("v6_not_yet3", q_s, 1'b0);
    at(551);  chk("v2_end", q_a, 1'b0); chk("v5_end3", q_b, 1'b0);
    at(571);  chk("v6_rise2", q_s, 1'b1);
    at(591);  chk("v6_end2", q_s, 1'b0);

    at(600);  load_w = 1'b1;
    at(611);  chk("v3_c1", q_w, 1'b1);
    at(620);  load_w = 1'b0;
    at(631);  chk("v3_c2", q_w, 1'b1);
    at(640);  load_w = 1'b1;
    at(651);  chk("v3_c3_retrig_ignored", q_w, 1'b1);
    at(660);  load_w = 1'b0;
    at(671);  chk("v3_c4", q_w, 1'b1);
    at(691);  chk("v3_end", q_w, 1'b0);
    at(700);  load_w = 1'b1;
    at(711);  chk("min_gap_restart", q_w, 1'b1);
    at(771);  chk("restart_c4", q_w, 1'b1);
    at(791);  chk("restart_end", q_w, 1'b0);
    at(851);  chk("w_held_no_repeat", q_w, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
